// File: rtl/data_mem_controller.sv
// Load/store sequencer and round-robin core/debug arbiter in front of a
// byte-enabled data memory whose read data is valid one cycle after the address.
//
// state | meaning
// IDLE  | sample requests, arbitrate, check and latch the granted access
// ISSUE | mem_addr / mem_we / mem_wd presented to memory for one cycle
// WAIT  | memory read data valid; extract, extend, register into rdata
// ACK   | one-cycle ack to the granted port, then back to IDLE
module data_mem_controller #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ack,
  output logic [31:0] core_rdata,
  output logic        core_fault,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_fault,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        core_fault_q, core_fault_d;
  logic        dbg_fault_q, dbg_fault_d;

  logic        grant_core, grant_dbg;
  logic        core_f3_ok, core_misal, core_oor, dbg_oor;
  logic        sel_port, sel_we, sel_fault;
  logic [2:0]  sel_funct3;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  lane_we;
  logic [31:0] lane_wd;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        res_valid, res_port, res_fault;
  logic [31:0] res_data;

  // Arbitration and request checking; debug is treated as an aligned word access.
  always_comb begin
    grant_core = core_req && (!dbg_req || (last_grant_q == PORT_DBG));
    grant_dbg  = dbg_req && !grant_core;

    if (core_we) begin
      core_f3_ok = core_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      core_f3_ok = core_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    core_misal = ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                 ((core_funct3[1:0] == 2'b10) && (core_addr[1:0] != 2'b00));
    core_oor   = (core_addr >> (ADDR_W + 2)) != 32'd0;
    dbg_oor    = (dbg_addr >> (ADDR_W + 2)) != 32'd0;

    if (grant_core) begin
      sel_port   = PORT_CORE;
      sel_we     = core_we;
      sel_funct3 = core_funct3;
      sel_addr   = core_addr;
      sel_wdata  = core_wdata;
      sel_fault  = !core_f3_ok || core_misal || core_oor;
    end else begin
      sel_port   = PORT_DBG;
      sel_we     = dbg_we;
      sel_funct3 = 3'b010;
      sel_addr   = {dbg_addr[31:2], 2'b00};
      sel_wdata  = dbg_wdata;
      sel_fault  = dbg_oor;
    end
  end

  always_comb begin
    case (sel_funct3[1:0])
      2'b00: begin
        lane_we = 4'b0001 << sel_addr[1:0];
        lane_wd = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        lane_we = sel_addr[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{sel_wdata[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        lane_wd = sel_wdata;
      end
    endcase
  end

  // Load extraction; funct3[2] selects zero- over sign-extension.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rd[7:0];
      2'd1:    ld_byte = mem_rd[15:8];
      2'd2:    ld_byte = mem_rd[23:16];
      default: ld_byte = mem_rd[31:24];
    endcase
    ld_half = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_val = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = mem_rd;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_we_d     = 4'b0000;
    mem_addr_d   = 32'd0;
    mem_wd_d     = 32'd0;
    core_rdata_d = core_rdata_q;
    core_fault_d = core_fault_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_fault_d  = dbg_fault_q;
    res_valid    = 1'b0;
    res_port     = port_q;
    res_fault    = 1'b0;
    res_data     = 32'd0;

    case (state_q)
      IDLE: begin
        if (grant_core || grant_dbg) begin
          last_grant_d = sel_port;
          port_d       = sel_port;
          we_d         = sel_we;
          funct3_d     = sel_funct3;
          off_d        = sel_addr[1:0];
          if (sel_fault) begin
            state_d   = ACK;
            res_valid = 1'b1;
            res_port  = sel_port;
            res_fault = 1'b1;
          end else begin
            state_d    = ISSUE;
            mem_addr_d = {{(32 - ADDR_W){1'b0}}, sel_addr[ADDR_W+1:2]};
            if (sel_we) begin
              mem_we_d = lane_we;
              mem_wd_d = lane_wd;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d   = ACK;
          res_valid = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d   = ACK;
        res_valid = 1'b1;
        res_data  = ld_val;
      end
      default: state_d = IDLE;
    endcase

    if (res_valid) begin
      if (res_port == PORT_CORE) begin
        core_rdata_d = res_data;
        core_fault_d = res_fault;
      end else begin
        dbg_rdata_d = res_data;
        dbg_fault_d = res_fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DBG;
      port_q       <= PORT_CORE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= 32'd0;
      mem_wd_q     <= 32'd0;
      core_rdata_q <= 32'd0;
      core_fault_q <= 1'b0;
      dbg_rdata_q  <= 32'd0;
      dbg_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      core_rdata_q <= core_rdata_d;
      core_fault_q <= core_fault_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_fault_q  <= dbg_fault_d;
    end
  end

  // Reset asserted during ISSUE lands on the same edge the memory would write,
  // so the enables are masked by rst to keep an aborted store from landing.
  assign mem_we     = mem_we_q & {4{~rst}};
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign core_ack   = (state_q == ACK) && (port_q == PORT_CORE);
  assign dbg_ack    = (state_q == ACK) && (port_q == PORT_DBG);
  assign core_rdata = core_rdata_q;
  assign core_fault = core_fault_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_fault  = dbg_fault_q;

endmodule
